// File: rtl/approx_mul_err_sweeper.sv
// ---------------------------------------------------------------------------
// approx_mul_err_sweeper
//
// Exhaustive error-evaluation controller for a small combinational approximate
// multiplier. A vector counter walks every input pattern. Each pattern is
// driven out on dut_in. The returned approximate product is compared against
// the exact unsigned product A*B, where A = dut_in[IN_W/2-1:0] and
// B = dut_in[IN_W-1:IN_W/2]. The block accumulates the maximum absolute
// error, the vector that first reached it, the error sum and the number of
// mismatching vectors. It then issues a pass verdict against threshold ET.
//
// Parameters
//   IN_W       total multiplier input bits (even)
//   OUT_W      multiplier output bits (equal to IN_W)
//   ET         error threshold; pass requires max_err <= ET
//   EARLY_EXIT 1 = stop on the first vector whose error exceeds ET
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          begin a sweep (honoured only when idle)
//   abort          cancel a running sweep (partial statistics are kept)
//   dut_in         vector to the multiplier (zero when not sweeping)
//   dut_out        approximate product, combinational from dut_in
//   busy           sweep in progress
//   done           one-cycle pulse; results valid
//   aborted        last run was cancelled (sticky until next start)
//   pass           max_err <= ET for the last completed run
//   max_err        largest |exact - approx| observed
//   worst_vec      earliest vector that produced max_err
//   err_sum        sum of |exact - approx|
//   mismatch_cnt   number of vectors with a nonzero error
// ---------------------------------------------------------------------------
module approx_mul_err_sweeper #(
  parameter int IN_W       = 4,
  parameter int OUT_W      = 4,
  parameter int ET         = 7,
  parameter int EARLY_EXIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  pass,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W-1:0]       worst_vec,
  output logic [OUT_W+IN_W-1:0] err_sum,
  output logic [IN_W:0]         mismatch_cnt
);

  localparam int                HW   = IN_W / 2;
  localparam logic [OUT_W-1:0]  ET_V = OUT_W'(ET);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IN_W-1:0]         vec_q, vec_d;
  logic [OUT_W-1:0]        max_err_q, max_err_d;
  logic [IN_W-1:0]         worst_vec_q, worst_vec_d;
  logic [OUT_W+IN_W-1:0]   err_sum_q, err_sum_d;
  logic [IN_W:0]           mis_q, mis_d;
  logic                    pass_q, pass_d;
  logic                    aborted_q, aborted_d;

  // Exact reference and absolute error for the vector currently presented.
  logic [IN_W-1:0]         exact;
  logic [OUT_W-1:0]        err;
  logic                    err_new_max;
  logic [OUT_W-1:0]        max_after;
  logic                    sweep_end;

  // Operands are zero-extended so the product is formed at full IN_W width.
  assign exact       = {{(IN_W-HW){1'b0}}, vec_q[HW-1:0]} *
                       {{HW{1'b0}}, vec_q[IN_W-1:HW]};
  assign err         = (exact >= dut_out) ? (exact - dut_out) : (dut_out - exact);
  // Strict compare: a tie keeps the earlier worst vector.
  assign err_new_max = err > max_err_q;
  assign max_after   = err_new_max ? err : max_err_q;
  assign sweep_end   = (vec_q == '1) || ((EARLY_EXIT != 0) && (err > ET_V));

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    vec_d       = vec_q;
    max_err_d   = max_err_q;
    worst_vec_d = worst_vec_q;
    err_sum_d   = err_sum_q;
    mis_d       = mis_q;
    pass_d      = pass_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d       = '0;
          max_err_d   = '0;
          worst_vec_d = '0;
          err_sum_d   = '0;
          mis_d       = '0;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
          state_d     = S_SWEEP;
        end
      end

      S_SWEEP: begin
        if (abort) begin
          // Current vector is dropped; statistics so far are held.
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          err_sum_d = err_sum_q + (OUT_W+IN_W)'(err);
          mis_d     = mis_q + {{IN_W{1'b0}}, (err != '0)};
          if (err_new_max) begin
            max_err_d   = err;
            worst_vec_d = vec_q;
          end
          if (sweep_end) begin
            // Verdict uses statistics that include this final vector, so it
            // is already valid while done is high.
            pass_d  = (max_after <= ET_V);
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      max_err_q   <= '0;
      worst_vec_q <= '0;
      err_sum_q   <= '0;
      mis_q       <= '0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      max_err_q   <= max_err_d;
      worst_vec_q <= worst_vec_d;
      err_sum_q   <= err_sum_d;
      mis_q       <= mis_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
    end
  end

  assign busy         = (state_q == S_SWEEP);
  assign done         = (state_q == S_DONE);
  assign dut_in       = busy ? vec_q : '0;
  assign aborted      = aborted_q;
  assign pass         = pass_q;
  assign max_err      = max_err_q;
  assign worst_vec    = worst_vec_q;
  assign err_sum      = err_sum_q;
  assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_err_sweeper
//
// Directed bench for approx_mul_err_sweeper (IN_W = OUT_W = 4, ET = 7).
// Instance 0 runs full sweeps. Instance 1 has early exit enabled. Each
// instance sees a behavioural multiplier selected by mode:
//   0 exact A*B
//   1 stuck at zero
//   2 A*B with bit 3 flipped
//   3 exact, except vector 4'b0110 is off by exactly ET
// ---------------------------------------------------------------------------
module tb_approx_mul_err_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] abort;
  int         mode [2];

  logic [3:0] dut_in       [2];
  logic [3:0] dut_out      [2];
  logic       busy         [2];
  logic       done         [2];
  logic       aborted      [2];
  logic       pass         [2];
  logic [3:0] max_err      [2];
  logic [3:0] worst_vec    [2];
  logic [7:0] err_sum      [2];
  logic [4:0] mismatch_cnt [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] model(input int m, input logic [3:0] v);
    logic [3:0] p;
    p = {2'b00, v[1:0]} * {2'b00, v[3:2]};
    case (m)
      0:       return p;
      1:       return 4'd0;
      2:       return p ^ 4'b1000;
      default: return (v == 4'b0110) ? p + 4'd7 : p;
    endcase
  endfunction

  always_comb begin
    dut_out[0] = model(mode[0], dut_in[0]);
    dut_out[1] = model(mode[1], dut_in[1]);
  end

  approx_mul_err_sweeper #(.IN_W(4), .OUT_W(4), .ET(7), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
    .aborted(aborted[0]), .pass(pass[0]), .max_err(max_err[0]),
    .worst_vec(worst_vec[0]), .err_sum(err_sum[0]), .mismatch_cnt(mismatch_cnt[0])
  );

  approx_mul_err_sweeper #(.IN_W(4), .OUT_W(4), .ET(7), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
    .aborted(aborted[1]), .pass(pass[1]), .max_err(max_err[1]),
    .worst_vec(worst_vec[1]), .err_sum(err_sum[1]), .mismatch_cnt(mismatch_cnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge. Pulses (or holds) start, then counts edges
  // from the sampling edge until done is seen, bounded at 100 edges.
  task automatic run(input int sel, input bit hold, output int edges);
    start[sel] = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!hold) start[sel] = 1'b0;
      if (edges == 1) begin
        check("busy_first_cycle", busy[sel], 1);
        check("vec0_presented",   dut_in[sel], 0);
        check("aborted_cleared",  aborted[sel], 0);
      end
    end while (!done[sel] && edges < 100);
    check("done_seen",    done[sel], 1);
    check("busy_in_done", busy[sel], 0);
  endtask

  task automatic results(input int sel, input int mx, input int wv, input int sm,
                         input int mc, input int ps);
    check("max_err",      max_err[sel], mx);
    check("worst_vec",    worst_vec[sel], wv);
    check("err_sum",      err_sum[sel], sm);
    check("mismatch_cnt", mismatch_cnt[sel], mc);
    check("pass",         pass[sel], ps);
  endtask

  task automatic wait_vec(input int sel, input int v);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (dut_in[sel] == 4'(v)) found = 1'b1;
    end
    check("wait_vec_reached", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int saw;
    rst   = 1'b1;
    start = 2'b00;
    abort = 2'b00;
    mode[0] = 0;
    mode[1] = 0;

    // Reset state.
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_busy",   busy[s], 0);
      check("rst_done",   done[s], 0);
      check("rst_dut_in", dut_in[s], 0);
      check("rst_aborted", aborted[s], 0);
      results(s, 0, 0, 0, 0, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact multiplier: no error, pass, done 17 edges after start sampling.
    mode[0] = 0;
    run(0, 1'b0, edges);
    check("exact_latency", edges, 17);
    results(0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done[0], 0);

    // Stuck-at-zero: errors are the products themselves.
    mode[0] = 1;
    run(0, 1'b0, edges);
    check("stuck_latency", edges, 17);
    results(0, 9, 15, 36, 9, 0);
    @(posedge clk); #1;

    // Bit-3 flip: every vector off by 8; ties keep vector 0.
    mode[0] = 2;
    run(0, 1'b0, edges);
    results(0, 8, 0, 128, 16, 0);
    @(posedge clk); #1;

    // Same with early exit: stops after vector 0.
    mode[1] = 2;
    run(1, 1'b0, edges);
    check("early_latency", edges, 2);
    results(1, 8, 0, 8, 1, 0);
    @(posedge clk); #1;

    // Error exactly at threshold: still passes, early exit does not trigger.
    mode[0] = 3;
    run(0, 1'b0, edges);
    results(0, 7, 6, 7, 1, 1);
    @(posedge clk); #1;
    mode[1] = 3;
    run(1, 1'b0, edges);
    check("early_at_et_latency", edges, 17);
    results(1, 7, 6, 7, 1, 1);
    @(posedge clk); #1;

    // Abort while vector 5 is presented: vectors 0..4 counted, no done.
    mode[0] = 2;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("abort_run_busy", busy[0], 1);
    wait_vec(0, 5);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    check("abort_busy",    busy[0], 0);
    check("abort_done",    done[0], 0);
    check("abort_aborted", aborted[0], 1);
    check("abort_dut_in",  dut_in[0], 0);
    results(0, 8, 0, 40, 5, 0);
    saw = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done[0]) saw = 1;
    end
    check("abort_no_done", saw, 0);
    check("abort_sticky",  aborted[0], 1);

    // Fresh start after abort completes normally.
    mode[0] = 0;
    run(0, 1'b0, edges);
    check("restart_latency", edges, 17);
    check("restart_aborted", aborted[0], 0);
    results(0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;

    // Start held high through the sweep and the done cycle: one sweep only.
    mode[0] = 1;
    run(0, 1'b1, edges);
    check("hold_latency", edges, 17);
    results(0, 9, 15, 36, 9, 0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("hold_no_restart", busy[0], 0);
    check("hold_done_low",   done[0], 0);
    @(posedge clk); #1;
    check("hold_still_idle", busy[0], 0);

    // Asynchronous reset while vector 7 is presented.
    mode[0] = 1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_vec(0, 7);
    check("pre_rst_err_sum", err_sum[0], 3);
    check("pre_rst_mis",     mismatch_cnt[0], 2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",    busy[0], 0);
    check("arst_dut_in",  dut_in[0], 0);
    check("arst_done",    done[0], 0);
    check("arst_aborted", aborted[0], 0);
    results(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", busy[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
